// File: rtl/gen_mask_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : gen_mask_rr_arb
// Description : Round-robin arbiter with per-channel elaboration mask.
//               Only channels with MASK[g]=1 take part in arbitration and
//               get a grant counter; masked-off channels are tied to zero.
//               One registered grant is offered at a time (valid/ack).
//               The grant counters exist only when GEN_ARB_STATS_EN is
//               defined; otherwise cnt_flat is tied to zero.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               req        - per-channel request level [SIZE]
//               ack        - consumer accepts current grant
//               gnt_valid  - a grant is being offered
//               gnt        - one-hot grant, zero when idle [SIZE]
//               gnt_id     - binary index of granted channel [IDW]
//               cnt_flat   - per-channel saturating accepted-grant counters,
//                            channel g at [g*CNT_W +: CNT_W]
// Macro       : GEN_ARB_STATS_EN - elaborate per-channel grant counters
// Revision    : 1.0 - initial release
// ============================================================================
module gen_mask_rr_arb #(
  parameter int              SIZE  = 4,
  parameter logic [SIZE-1:0] MASK  = {SIZE{1'b1}},
  parameter int              CNT_W = 8,
  localparam int             IDW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SIZE-1:0]       req,
  input  logic                  ack,
  output logic                  gnt_valid,
  output logic [SIZE-1:0]       gnt,
  output logic [IDW-1:0]        gnt_id,
  output logic [SIZE*CNT_W-1:0] cnt_flat
);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_grant = 1'b1;

  logic [0:0]      r_state;
  logic [IDW-1:0]  r_ptr;
  logic            r_gnt_valid;
  logic [SIZE-1:0] r_gnt;
  logic [IDW-1:0]  r_gnt_id;

  logic [SIZE-1:0] w_elig;
  logic [IDW-1:0]  w_ptr_inc;
  logic [IDW-1:0]  w_arb_ptr;
  logic [IDW:0]    w_sum;
  logic [IDW-1:0]  w_cand;
  logic            w_any;
  logic [IDW-1:0]  w_win;
  logic [SIZE-1:0] w_win_oh;
  logic            w_accept;

  // Eligibility: masked-off channels never drive anything. The outer range
  // test keeps every MASK/req index inside 0..SIZE-1.
  genvar g;
  generate
    for (g = 0; g < SIZE; g++) begin : g_elig
      if (g < SIZE) begin : g_in
        if (MASK[g]) begin : g_en
          assign w_elig[g] = req[g];
        end else begin : g_off
          assign w_elig[g] = 1'b0;
        end
      end
    end
  endgenerate

  // Pointer after the current grant is accepted, wrapping at SIZE.
  assign w_ptr_inc = (r_gnt_id == IDW'(SIZE - 1)) ? '0 : r_gnt_id + 1'b1;

  // In GRANT the search only matters on an accepting cycle, where the
  // updated pointer must already apply to the back-to-back winner.
  assign w_arb_ptr = (r_state == c_st_grant) ? w_ptr_inc : r_ptr;

  // Search ptr, ptr+1, ..., wrapping at SIZE; first eligible channel wins.
  // One extra bit on the sum keeps ptr+offset from overflowing before wrap.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int i = 0; i < SIZE; i++) begin
      w_sum = {1'b0, w_arb_ptr} + (IDW+1)'(i);
      if (w_sum >= (IDW+1)'(SIZE)) begin
        w_sum = w_sum - (IDW+1)'(SIZE);
      end
      w_cand = w_sum[IDW-1:0];
      if (!w_any && w_elig[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_win_oh = SIZE'(1) << w_win;
  assign w_accept = (r_state == c_st_grant) && ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_ptr       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_any) begin
            r_state     <= c_st_grant;
            r_gnt_valid <= 1'b1;
            r_gnt       <= w_win_oh;
            r_gnt_id    <= w_win;
          end
        end
        c_st_grant: begin
          // Grant is held regardless of req until the consumer accepts it.
          if (ack) begin
            r_ptr <= w_ptr_inc;
            if (w_any) begin
              r_gnt    <= w_win_oh;
              r_gnt_id <= w_win;
            end else begin
              r_state     <= c_st_idle;
              r_gnt_valid <= 1'b0;
              r_gnt       <= '0;
              r_gnt_id    <= '0;
            end
          end
        end
        default: begin
          r_state     <= c_st_idle;
          r_gnt_valid <= 1'b0;
          r_gnt       <= '0;
          r_gnt_id    <= '0;
        end
      endcase
    end
  end

  assign gnt_valid = r_gnt_valid;
  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;

`ifdef GEN_ARB_STATS_EN
  generate
    for (g = 0; g < SIZE; g++) begin : g_cnt
      if (g < SIZE) begin : g_in
        if (MASK[g]) begin : g_en
          logic [CNT_W-1:0] r_cnt;
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              r_cnt <= '0;
            end else if (w_accept && r_gnt[g] && !(&r_cnt)) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          assign cnt_flat[g*CNT_W +: CNT_W] = r_cnt;
        end else begin : g_off
          assign cnt_flat[g*CNT_W +: CNT_W] = '0;
        end
      end
    end
  endgenerate
`else
  assign cnt_flat = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gen_mask_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_gen_mask_rr_arb
// Description : Directed self-checking bench for gen_mask_rr_arb. Three
//               instances: full 4-channel with 2-bit counters, 4-channel with
//               MASK=1010, and 3-channel with MASK=011. Expected counter
//               values follow GEN_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_mask_rr_arb;

`ifdef GEN_ARB_STATS_EN
  localparam bit c_stats = 1'b1;
`else
  localparam bit c_stats = 1'b0;
`endif

  logic clk;
  logic rst_n;

  logic [3:0]  req_a, gnt_a, req_b, gnt_b;
  logic        ack_a, gv_a, ack_b, gv_b, ack_c, gv_c;
  logic [1:0]  id_a, id_b, id_c;
  logic [7:0]  cnt_a;
  logic [31:0] cnt_b;
  logic [2:0]  req_c, gnt_c;
  logic [23:0] cnt_c;

  int n_vec = 0;
  int n_err = 0;

  gen_mask_rr_arb #(.SIZE(4), .MASK(4'b1111), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .ack(ack_a),
    .gnt_valid(gv_a), .gnt(gnt_a), .gnt_id(id_a), .cnt_flat(cnt_a));

  gen_mask_rr_arb #(.SIZE(4), .MASK(4'b1010), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .ack(ack_b),
    .gnt_valid(gv_b), .gnt(gnt_b), .gnt_id(id_b), .cnt_flat(cnt_b));

  gen_mask_rr_arb #(.SIZE(3), .MASK(3'b011), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .ack(ack_c),
    .gnt_valid(gv_c), .gnt(gnt_c), .gnt_id(id_c), .cnt_flat(cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0; ack_a = 1'b0;
    req_b = '0; ack_b = 1'b0;
    req_c = '0; ack_c = 1'b0;
    repeat (3) tick;
    chk("rst_valid", 64'(gv_a), 64'd0);
    chk("rst_gnt",   64'(gnt_a), 64'd0);
    chk("rst_id",    64'(id_a), 64'd0);
    chk("rst_cnt",   64'(cnt_a), 64'd0);

    rst_n = 1'b1;
    tick;
    chk("idle_noreq", 64'(gv_a), 64'd0);

    // All requesting, ack held: ids 0,1,2,3,0 back to back.
    req_a = 4'hF; ack_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("rr_valid", 64'(gv_a), 64'd1);
      chk("rr_id",    64'(id_a), 64'(k % 4));
      chk("rr_gnt",   64'(gnt_a), 64'(4'b0001 << (k % 4)));
    end
    chk("rr_cnt", 64'(cnt_a), c_stats ? 64'h55 : 64'h0);

    // Grant 0 held with ack low and request gone.
    req_a = 4'h0; ack_a = 1'b0;
    repeat (5) begin
      tick;
      chk("hold0_gnt", 64'(gnt_a), 64'h1);
      chk("hold0_valid", 64'(gv_a), 64'd1);
    end
    ack_a = 1'b1;
    tick;
    chk("ack0_idle_valid", 64'(gv_a), 64'd0);
    chk("ack0_idle_gnt",   64'(gnt_a), 64'd0);
    chk("ack0_cnt", 64'(cnt_a), c_stats ? 64'h56 : 64'h0);

    // Grant id 2 (ptr is 1), then drop req[2] and stall.
    ack_a = 1'b0; req_a = 4'b0100;
    tick;
    chk("g2_id", 64'(id_a), 64'd2);
    req_a = 4'h0;
    repeat (5) begin
      tick;
      chk("hold2_gnt", 64'(gnt_a), 64'h4);
      chk("hold2_id",  64'(id_a), 64'd2);
    end
    ack_a = 1'b1;
    tick;
    chk("ack2_idle", 64'(gv_a), 64'd0);
    chk("ack2_cnt", 64'(cnt_a), c_stats ? 64'h66 : 64'h0);

    // ptr is now 3: all requesting gives id 3 first.
    ack_a = 1'b0; req_a = 4'hF;
    tick;
    chk("ptr3_id", 64'(id_a), 64'd3);
    chk("ptr3_valid", 64'(gv_a), 64'd1);

    // Asynchronous reset mid-GRANT, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(gv_a), 64'd0);
    chk("arst_gnt",   64'(gnt_a), 64'd0);
    chk("arst_id",    64'(id_a), 64'd0);
    chk("arst_cnt",   64'(cnt_a), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_rst_id",  64'(id_a), 64'd0);
    chk("post_rst_gnt", 64'(gnt_a), 64'h1);

    // Channel 0 accepted six times: 2-bit counter saturates at 3.
    req_a = 4'b0001; ack_a = 1'b1;
    repeat (6) begin
      tick;
      chk("sat_id",    64'(id_a), 64'd0);
      chk("sat_valid", 64'(gv_a), 64'd1);
    end
    chk("sat_cnt", 64'(cnt_a), c_stats ? 64'h03 : 64'h0);
    req_a = 4'h0;
    tick;
    chk("sat_idle", 64'(gv_a), 64'd0);
    chk("sat_cnt_hold", 64'(cnt_a), c_stats ? 64'h03 : 64'h0);
    ack_a = 1'b0;

    // Masked instances: b grants 1,3,1,3; c (SIZE=3) grants 0,1,0,1.
    req_b = 4'hF; ack_b = 1'b1;
    req_c = 3'b111; ack_c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("mask_b_id",  64'(id_b), (k % 2) ? 64'd3 : 64'd1);
      chk("mask_b_gnt", 64'(gnt_b), (k % 2) ? 64'h8 : 64'h2);
      chk("np2_c_id",   64'(id_c), 64'(k % 2));
      chk("np2_c_gnt",  64'(gnt_c), (k % 2) ? 64'h2 : 64'h1);
    end
    chk("mask_b_cnt", 64'(cnt_b), c_stats ? 64'h0100_0200 : 64'h0);
    chk("np2_c_cnt",  64'(cnt_c), c_stats ? 64'h00_0102 : 64'h0);
    req_b = 4'h0; req_c = 3'b000;
    tick;
    chk("mask_b_idle", 64'(gv_b), 64'd0);
    chk("np2_c_idle",  64'(gv_c), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gen_mask_rr_arb.md
# gen_mask_rr_arb

Parametrised round-robin arbiter whose request channels are selectively elaborated by a per-channel MASK parameter. Only channels with MASK[g]=1 get arbitration and statistics logic. Masked-off channels are absent from the netlist, and no generate condition ever indexes MASK or req outside 0..SIZE-1. The block sits between SIZE request sources and one shared downstream consumer, and issues one registered grant at a time with a valid/ack handshake.

## Interface
- SIZE, 4, number of channels (1..32)
- MASK, {SIZE{1'b1}}, SIZE-bit channel enable; bit g=0 means channel g is not elaborated
- CNT_W, 8, width of each per-channel grant counter (2..32)
- IDW, derived, SIZE>1 ? $clog2(SIZE) : 1; localparam, not overridable

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  SIZE  per-channel request level
- ack  input  1  consumer accepts current grant (qualified by gnt_valid)
- gnt_valid  output  1  a grant is being offered
- gnt  output  SIZE  one-hot grant; all zero when gnt_valid=0
- gnt_id  output  IDW  binary index of granted channel; 0 when idle
- cnt_flat  output  SIZE*CNT_W  per-channel accepted-grant counters; channel g occupies bits [g*CNT_W +: CNT_W]

## Operation
- Eligible set: elig[g] = MASK[g] & req[g].
  - Generate uses a nested if: outer g<SIZE, inner MASK[g]. A single && expression is not used.
  - For a non-elaborated channel, elig, gnt and the counter are tied to 0.
- Round-robin pointer ptr (IDW bits) marks the highest-priority channel. Search order is ptr, ptr+1, …, SIZE-1, 0, …, ptr-1, with wrap at SIZE rather than 2^IDW.
- FSM, two states:
  - IDLE: if any elig bit is set, register the winner into gnt/gnt_id, set gnt_valid, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: hold gnt, gnt_id and gnt_valid constant until ack=1. The grant is held even if the granted req drops.
  - GRANT with ack=1:
    - ptr := (gnt_id+1) wrapped at SIZE.
    - The counter of the granted channel increments.
    - If elig is non-zero this cycle, re-arbitrate with the new ptr and stay in GRANT with the new winner (back-to-back). Otherwise go to IDLE and clear gnt/gnt_valid.
- ack is ignored in IDLE.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- MASK=0: the block never leaves IDLE and all outputs stay 0.
- SIZE=1: ptr stays 0.

## Timing
- Reset values: state=IDLE, ptr=0, gnt_valid=0, gnt=0, gnt_id=0, all counters 0.
- Reset is asynchronous. Asserting rst_n mid-GRANT drops gnt_valid immediately, without waiting for a clock edge.
- Request to grant latency is 1 cycle: req seen at edge N, gnt_valid=1 after edge N.
- Throughput is one grant per cycle while ack is held high and elig is non-zero.
- Outputs are registered; there is no combinational path from req or ack to any output.
- A counter updates on the same edge as the accepting ack.

## Configuration
- GEN_ARB_STATS_EN:
  - Defined: the per-channel saturating counters are elaborated and drive cnt_flat.
  - Undefined: no counter flops exist and cnt_flat is tied to 0. Arbitration behaviour is identical in both builds.

## Test plan
- SIZE=4, MASK=4'b1111, req=4'b1111, ack held 1 -> gnt_id sequence 0,1,2,3,0, one grant per cycle, gnt_valid continuous.
- SIZE=4, MASK=4'b1010, req=4'b1111 -> only ids 1,3 are granted, alternating; gnt[0] and gnt[2] never assert; their counters stay 0.
- Grant id 2, req[2] dropped, ack held 0 for 5 cycles -> gnt=4'b0100 stable; on ack, ptr becomes 3 and the state returns to IDLE if no elig.
- CNT_W=2, one channel acked 6 times with GEN_ARB_STATS_EN defined -> counter reads 3 (saturated). Same test without the macro -> cnt_flat=0.
- rst_n pulsed low mid-GRANT -> gnt_valid, gnt and gnt_id are 0 before the next edge; the first grant after release starts from ptr=0.
- SIZE=3, MASK=3'b011 (non-power-of-two): req=3'b111 with ack=1 -> ids 0,1,0,1 with wrap at 3; no out-of-range index warnings at elaboration.
